// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency results (loads, mul, div).
// Stalls issue on RAW/WAW/capacity hazards and clears entries on writeback.

module reg_scoreboard_entry (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic pend
);
    // Flush beats everything; a set beats a clear of the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pend <= 1'b0;
        else if (flush) pend <= 1'b0;
        else if (set)   pend <= 1'b1;
        else if (clr)   pend <= 1'b0;
    end
endmodule

module reg_scoreboard #(
    parameter  int REG_ID_WIDTH    = 5,
    parameter  int NUM_REGS        = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic                    issue_long,
    input  logic                    issue_reg_write,
    input  logic [REG_ID_WIDTH-1:0] issue_dest,
    input  logic [REG_ID_WIDTH-1:0] issue_src1,
    input  logic [REG_ID_WIDTH-1:0] issue_src2,
    input  logic                    issue_use1,
    input  logic                    issue_use2,
    input  logic                    wb_valid,
    input  logic [REG_ID_WIDTH-1:0] wb_dest,
    input  logic                    flush,
    output logic                    stall,
    output logic                    issue_fire,
    output logic [NUM_REGS-1:0]     pending,
    output logic [CW-1:0]           outstanding
);
    logic          eff_src1, eff_src2, eff_dest;
    logic          raw_haz, waw_haz, cap_haz;
    logic          dest_nz, long_write, wb_hit, set_en;
    logic [CW-1:0] out_base;

    // A writeback landing this cycle hides its register from hazard checks.
    assign eff_src1 = pending[issue_src1] && !(wb_valid && wb_dest == issue_src1);
    assign eff_src2 = pending[issue_src2] && !(wb_valid && wb_dest == issue_src2);
    assign eff_dest = pending[issue_dest] && !(wb_valid && wb_dest == issue_dest);

    assign dest_nz    = issue_dest != '0;
    assign long_write = issue_long && issue_reg_write && dest_nz;
    assign wb_hit     = wb_valid && (wb_dest != '0) && pending[wb_dest];
    assign out_base   = outstanding - CW'(wb_hit);

    assign raw_haz = (issue_use1 && issue_src1 != '0 && eff_src1) ||
                     (issue_use2 && issue_src2 != '0 && eff_src2);
    assign waw_haz = issue_reg_write && dest_nz && eff_dest;
    assign cap_haz = long_write && (out_base == CW'(MAX_OUTSTANDING));

    assign stall      = issue_valid && !flush && (raw_haz || waw_haz || cap_haz);
    assign issue_fire = issue_valid && !stall;
    assign set_en     = issue_fire && long_write && !flush;

    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        reg_scoreboard_entry u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .set   (set_en && (issue_dest == REG_ID_WIDTH'(r))),
            .clr   (wb_hit && (wb_dest == REG_ID_WIDTH'(r))),
            .pend  (pending[r])
        );
    end

    // Set and clear of the same register cancel out in the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     outstanding <= '0;
        else if (flush) outstanding <= '0;
        else            outstanding <= outstanding + CW'(set_en) - CW'(wb_hit);
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= CW'(MAX_OUTSTANDING));
    a_cnt_pop: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(pending) == int'(outstanding));
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Pending-write scoreboard for the in-order pipeline, sitting at the decode/issue boundary opposite the EX-stage forwarding logic. Forwarding covers single-cycle ALU results in EX/MEM and MEM/WB. This block tracks results from long-latency units (loads, multiplier, divider) that cannot be forwarded in time. It records which architectural registers have an outstanding long-latency write, stalls issue on RAW/WAW hazards against them, and clears entries on writeback.

## Interface
- REG_ID_WIDTH, 5, register identifier width
- NUM_REGS, 32, architectural register count (2**REG_ID_WIDTH)
- MAX_OUTSTANDING, 4, maximum simultaneously pending long-latency writes (1..NUM_REGS-1)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction for issue this cycle
- issue_long  in  1  instruction writes its destination via a long-latency unit
- issue_reg_write  in  1  instruction writes a destination register
- issue_dest  in  REG_ID_WIDTH  destination register
- issue_src1, issue_src2  in  REG_ID_WIDTH  source registers
- issue_use1, issue_use2  in  1  corresponding source is actually read
- wb_valid  in  1  long-latency unit writes back this cycle
- wb_dest  in  REG_ID_WIDTH  writeback destination
- flush  in  1  pipeline flush (branch mispredict/exception)
- stall  out  1  hold decode; instruction not issued this cycle
- issue_fire  out  1  issue_valid && !stall
- pending  out  NUM_REGS  per-register pending-write bits (registered)
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of set pending bits (registered)

## Operation
- State: pending[NUM_REGS-1:0] and outstanding counter. Bit 0 is hardwired to 0 and is never set.
- Effective pending for hazard checks: eff[r] = pending[r] && !(wb_valid && wb_dest == r). A same-cycle writeback bypasses the hazard.
- RAW hazard: issue_use1 && eff[issue_src1], or the same for src2. Source register 0 never hazards.
- WAW hazard: issue_reg_write && issue_dest != 0 && eff[issue_dest].
- Capacity hazard: issue_long && issue_reg_write && issue_dest != 0 && outstanding_next_base == MAX_OUTSTANDING, where outstanding_next_base = outstanding − (wb clears a set bit ? 1 : 0).
- stall = issue_valid && !flush && (RAW || WAW || capacity). Stall is 0 when issue_valid is 0.
- Set: on issue_fire && issue_long && issue_reg_write && issue_dest != 0, pending[issue_dest] is set next cycle.
- Clear: wb_valid with wb_dest != 0 and pending[wb_dest]=1 clears that bit. A writeback to a non-pending register or to register 0 is ignored and does not change the count.
- Same register set and cleared in one cycle: the set wins, the bit stays 1, and the count is unchanged (clear −1, set +1).
- Count update: outstanding += set − clear, each term 0 or 1. It never exceeds MAX_OUTSTANDING and never underflows.
- flush: all pending bits and outstanding are cleared next cycle. A set or clear in the same cycle is discarded. Later writebacks to flushed registers are ignored, because their bit is already 0.
- Single-cycle (issue_long=0) writers never touch the scoreboard. Forwarding covers them.

## Timing
- Reset (rst_n low, asynchronous): pending = 0 and outstanding = 0 immediately. stall and issue_fire follow combinationally, so both are 0 while issue_valid is 0.
- stall and issue_fire are combinational from the current state and inputs, within the same cycle.
- Set/clear latency is 1 cycle: a bit set at edge N is visible on pending after edge N. A dependent instruction presented in cycle N+1 stalls.
- Writeback bypass has 0 latency: a dependent instruction presented in the same cycle as the matching wb_valid issues without stalling.
- Reset asserted mid-operation discards all pending state. There is no recovery of in-flight entries.

## Test plan
- Reset then idle: rst_n low with issue_valid=1 and src1=3 -> pending=0, outstanding=0, stall=0 after release.
- Load-use: issue long dest=5, next cycle issue use1 src1=5 -> pending[5]=1, stall=1. Assert wb_valid dest=5 -> stall=0 and issue_fire=1 in that same cycle, pending[5]=0 next cycle.
- WAW plus set/clear collision: pending[7]=1, issue long dest=7 with wb_valid dest=7 the same cycle -> stall=0, pending[7] stays 1, outstanding unchanged.
- Capacity: MAX_OUTSTANDING=4 with regs 1–4 pending, issue long dest=9 -> stall=1. Same cycle plus wb dest=2 -> stall=0, outstanding stays 4, pending[9]=1, pending[2]=0.
- Register 0: issue long dest=0, then use1 src1=0 -> no pending bit, stall=0, outstanding=0.
- Flush: regs 3 and 6 pending, flush=1 with a simultaneous long issue dest=8 -> all bits 0 and outstanding=0 next cycle. A later wb dest=3 -> no change.
